axis_dest_classifier: RTL and testbench
=======================================

// Module: axis_dest_classifier
// PURPOSE
// - Per-input-port classifier placed directly upstream of an axis_switch slave port.
// - Extracts a key field from the first beat of each frame and maps it through a parameter
//   table to tdest.
// - Holds that tdest constant for every beat of the frame; input tdest is ignored.
// - Registered skid output: 1-cycle latency, full throughput.
// PARAMETERS
// DATA_WIDTH    64                  tdata width (multiple of 8)
// KEEP_WIDTH    DATA_WIDTH/8        tkeep width
// ID_WIDTH      8                   tid width, passed through
// DEST_WIDTH    3                   tdest width; matches the switch's $clog2(M_COUNT+1)
// USER_WIDTH    1                   tuser width, passed through
// M_COUNT       4                   downstream switch outputs; mapped dest >= M_COUNT is unroutable
// FIELD_OFFSET  0                   bit offset of key field in first-beat tdata
// FIELD_WIDTH   2                   key width; table has 2**FIELD_WIDTH entries
// DEST_MAP      {3'd3,3'd2,3'd1,3'd0}  packed table, entry k at [k*DEST_WIDTH +: DEST_WIDTH]
// PORTS
// clk            in   1                 clock, all logic rising-edge
// rst            in   1                 synchronous reset, active-high
// s_axis_tdata   in   DATA_WIDTH        input data
// s_axis_tkeep   in   KEEP_WIDTH        input byte enables
// s_axis_tvalid  in   1                 input valid
// s_axis_tready  out  1                 input ready (registered)
// s_axis_tlast   in   1                 input end of frame
// s_axis_tid     in   ID_WIDTH          input id
// s_axis_tdest   in   DEST_WIDTH        ignored
// s_axis_tuser   in   USER_WIDTH        input user
// m_axis_*       out/in  same widths    output stream toward switch; m_axis_tready is the only input
// drop_frame     out  1                 1-cycle pulse per dropped frame (0 unless macro set)
// BEHAVIOUR
// - One clock (clk); reset rst is synchronous and active-high.
// - Reset: m_axis_tvalid=0, s_axis_tready=0, skid empty, state=IDLE, drop_frame=0.
//   s_axis_tready=1 on the first cycle after rst deasserts.
// - Handshake: beat accepted when s_axis_tvalid && s_axis_tready.
//   - Output beat held stable while m_axis_tvalid && !m_axis_tready.
//   - Two-entry skid (output reg + temp reg); s_axis_tready = temp reg empty, registered.
//   - Accepted beat appears on m_axis_* the next cycle if the output reg is free.
//   - Full throughput when m_axis_tready=1.
// - FSM IDLE (expecting first beat) / FRAME (dest latched) / DROP (macro only).
//   - IDLE, beat accepted:
//     - key = s_axis_tdata[FIELD_OFFSET +: FIELD_WIDTH].
//     - dest = DEST_MAP[key]; the beat is output with tdest=dest.
//     - If !tlast, latch dest and go to FRAME; single-beat frame stays IDLE.
//   - FRAME: beats output with latched dest; accepted beat with tlast goes to IDLE.
//   - tdata/tkeep/tid/tuser/tlast pass unchanged; m_axis_tdest never changes mid-frame.
// - Key bits beyond the first beat are never examined. Key straddling tkeep=0 bytes is still used.
// - rst mid-frame: skid flushed, beats lost, state=IDLE. The next accepted beat is treated as a
//   first beat.
// - m_axis_tready deasserted on the same cycle as a first-beat accept: the beat goes to the temp
//   reg and is classified correctly.
// CONFIGURATION
// - `define AXIS_DEST_CLASSIFIER_DROP_EN set:
//   - A first beat whose mapped dest >= M_COUNT is consumed, not output.
//   - drop_frame pulses the cycle that beat is accepted.
//   - State goes to DROP unless tlast; in DROP all beats are consumed (s_axis_tready stays 1)
//     until tlast, then IDLE.
//   - Dropping never stalls the input.
// - Macro not set:
//   - No DROP state; unroutable dest is forwarded as-is, for the switch to discard.
//   - drop_frame tied 0.
// TESTING
// - Reset: hold rst 3 cycles with s_axis_tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0.
//   Ready=1 the cycle after release.
// - Mapping: 4 single-beat frames, tdata[1:0]=0,1,2,3, m_axis_tready=1.
//   Outputs tdest=0,1,2,3, each 1 cycle after accept.
// - Hold: 5-beat frame, key=2, later beats' tdata[1:0]=1 and s_axis_tdest=7.
//   All 5 output beats tdest=2, data/tkeep/tid/tuser bit-exact, tlast only on beat 5.
// - Backpressure: m_axis_tready random 50% over 100 frames of 1..8 beats.
//   No loss/dup/reorder; output stable while stalled; tdest constant per frame.
// - Drop (macro set): DEST_MAP entry 3 = 3'd5, 3-beat frame with key=3, then a key=1 frame.
//   drop_frame one pulse, zero output beats, then the key=1 frame with tdest=1.
//   Macro unset: same stimulus forwards tdest=5.
// - Reset mid-frame: rst on beat 2 of 4, then new frame key=1.
//   No stale beats out; the new frame gets tdest=1.

Source files
------------

// File: rtl/axis_dest_classifier.sv
// -----------------------------------------------------------------------------
// axis_dest_classifier
//
// Per-input-port classifier placed directly upstream of an axis_switch slave
// port. The key field of the first beat of every frame is looked up in the
// DEST_MAP table. The resulting tdest is applied to every beat of that frame.
// The incoming tdest is ignored. The output is a two-entry registered skid
// buffer with one cycle of latency that sustains full throughput.
//
// Optional feature (macro AXIS_DEST_CLASSIFIER_DROP_EN):
//   When defined, a frame whose mapped dest is >= M_COUNT is consumed without
//   being forwarded, and drop_frame pulses when its first beat is accepted.
//   When undefined, such frames are forwarded unchanged so the switch can
//   discard them, and drop_frame is tied low.
//
// Ports:
//   clk             clock, all logic on the rising edge
//   rst             synchronous reset, active high
//   s_axis_t*       input stream (s_axis_tdest is ignored)
//   s_axis_tready   input ready, registered (high while the temp reg is empty)
//   m_axis_t*       output stream toward the switch
//   m_axis_tready   output ready from the switch
//   drop_frame      one-cycle pulse per dropped frame
// -----------------------------------------------------------------------------
module axis_dest_classifier #(
   parameter int DATA_WIDTH   = 64,
   parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
   parameter int ID_WIDTH     = 8,
   parameter int DEST_WIDTH   = 3,
   parameter int USER_WIDTH   = 1,
   parameter int M_COUNT      = 4,
   parameter int FIELD_OFFSET = 0,
   parameter int FIELD_WIDTH  = 2,
   parameter logic [(2**FIELD_WIDTH)*DEST_WIDTH-1:0] DEST_MAP = {3'd3, 3'd2, 3'd1, 3'd0}
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [ID_WIDTH-1:0]   s_axis_tid,
   input  logic [DEST_WIDTH-1:0] s_axis_tdest,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,

   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [ID_WIDTH-1:0]   m_axis_tid,
   output logic [DEST_WIDTH-1:0] m_axis_tdest,
   output logic [USER_WIDTH-1:0] m_axis_tuser,

   output logic                  drop_frame
);

   localparam int MAP_ENTRIES = 2**FIELD_WIDTH;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [KEEP_WIDTH-1:0] keep;
      logic                  last;
      logic [ID_WIDTH-1:0]   id;
      logic [DEST_WIDTH-1:0] dest;
      logic [USER_WIDTH-1:0] user;
   } beat_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // next accepted beat is the first beat of a frame
      FRAME = 2'd1    // mid-frame, dest latched in frame_dest_q
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
      , DROP = 2'd2   // mid-frame of an unroutable frame, beats consumed
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [DEST_WIDTH-1:0] frame_dest_q, frame_dest_d;

   logic [DEST_WIDTH-1:0] dest_table [MAP_ENTRIES];
   logic [FIELD_WIDTH-1:0] key;
   logic [DEST_WIDTH-1:0] map_dest;
   logic [DEST_WIDTH-1:0] beat_dest;
   logic                  unroutable;

   logic                  accept;
   logic                  drop_beat;
   logic                  push;
   beat_t                 in_beat;

   beat_t                 out_q, temp_q;
   logic                  out_valid_q, out_valid_d;
   logic                  temp_valid_q, temp_valid_d;
   logic                  ready_q;
   logic                  load_out_in, load_out_temp, load_temp;

`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
   logic                  drop_first;
`endif

   // Unpack the flat parameter table so the lookup index is exactly key-wide.
   for (genvar k = 0; k < MAP_ENTRIES; k++) begin : g_map
      assign dest_table[k] = DEST_MAP[k*DEST_WIDTH +: DEST_WIDTH];
   end

   // The key is taken regardless of tkeep: a key in disabled bytes still counts.
   assign key        = s_axis_tdata[FIELD_OFFSET +: FIELD_WIDTH];
   assign map_dest   = dest_table[key];
   assign unroutable = {1'b0, map_dest} >= (DEST_WIDTH+1)'(M_COUNT);

   assign accept = s_axis_tvalid && ready_q;
   assign push   = accept && !drop_beat;

   // -------------------------------------------------------------------------
   // Frame FSM: decides the dest carried by the beat currently on the input.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= IDLE;
         frame_dest_q <= '0;
      end else begin
         state_q      <= state_d;
         frame_dest_q <= frame_dest_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_d      = state_q;
      frame_dest_d = frame_dest_q;
      beat_dest    = frame_dest_q;
      drop_beat    = 1'b0;
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
      drop_first   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            beat_dest = map_dest;
            if (accept) begin
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
               if (unroutable) begin
                  drop_beat  = 1'b1;
                  drop_first = 1'b1;
                  if (!s_axis_tlast) state_d = DROP;
               end else if (!s_axis_tlast) begin
                  state_d      = FRAME;
                  frame_dest_d = map_dest;
               end
`else
               if (!s_axis_tlast) begin
                  state_d      = FRAME;
                  frame_dest_d = map_dest;
               end
`endif
            end
         end
         FRAME: begin
            if (accept && s_axis_tlast) state_d = IDLE;
         end
`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
         DROP: begin
            drop_beat = 1'b1;
            if (accept && s_axis_tlast) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign in_beat = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast,
                      id: s_axis_tid, dest: beat_dest, user: s_axis_tuser};

   // -------------------------------------------------------------------------
   // Skid buffer: out_q drives the port, temp_q catches the one beat accepted
   // while out_q is stalled. Input ready is simply "temp_q will be empty".
   // -------------------------------------------------------------------------
   always_comb begin
      out_valid_d   = out_valid_q;
      temp_valid_d  = temp_valid_q;
      load_out_in   = 1'b0;
      load_out_temp = 1'b0;
      load_temp     = 1'b0;
      if (push && (!out_valid_q || m_axis_tready)) begin
         load_out_in = 1'b1;
         out_valid_d = 1'b1;
      end else if (push) begin
         load_temp    = 1'b1;
         temp_valid_d = 1'b1;
      end else if (!out_valid_q || m_axis_tready) begin
         if (temp_valid_q) begin
            load_out_temp = 1'b1;
            out_valid_d   = 1'b1;
            temp_valid_d  = 1'b0;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         temp_valid_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         temp_valid_q <= temp_valid_d;
         ready_q      <= !temp_valid_d;
      end
   end

   // NOTE: payload registers are deliberately not reset; the valid flags
   // above qualify them, so flushing only the flags is sufficient.
   always_ff @(posedge clk) begin
      if (load_out_in) begin
         out_q <= in_beat;
      end else if (load_out_temp) begin
         out_q <= temp_q;
      end
      if (load_temp) begin
         temp_q <= in_beat;
      end
   end

   assign s_axis_tready = ready_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tdata  = out_q.data;
   assign m_axis_tkeep  = out_q.keep;
   assign m_axis_tlast  = out_q.last;
   assign m_axis_tid    = out_q.id;
   assign m_axis_tdest  = out_q.dest;
   assign m_axis_tuser  = out_q.user;

`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
   assign drop_frame = drop_first;
`else
   assign drop_frame = 1'b0;
`endif

   // Inputs/flags that are intentionally not consumed in every build.
   logic unused_ok;
   assign unused_ok = &{1'b0, s_axis_tdest, unroutable, 1'b0};

endmodule

// File: tb/tb_axis_dest_classifier.sv
// -----------------------------------------------------------------------------
// tb_axis_dest_classifier
//
// Two instances share one stimulus bus: dut_a uses the default table, dut_b
// maps key 3 to the unroutable dest 5. A select variable steers s_axis_tvalid
// to one of them at a time. Expected beats are pushed into a queue when the
// driver sees a beat accepted; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_axis_dest_classifier;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [7:0]  id;
      logic [2:0]  dest;
      logic        user;
   } beat_t;

   typedef struct {
      beat_t b;
      int    dut;
      int    cyc;
      bit    lat;
   } exp_t;

`ifdef AXIS_DEST_CLASSIFIER_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif
   localparam int M_COUNT = 4;

   // Reference tables for the two instances.
   int map_a [4] = '{0, 1, 2, 3};
   int map_b [4] = '{0, 1, 2, 5};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] s_tdata = '0;
   logic [7:0]  s_tkeep = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic [7:0]  s_tid = '0;
   logic [2:0]  s_tdest = '0;
   logic        s_tuser = 1'b0;
   logic        m_tready = 1'b1;
   int          sel = 0;
   bit          bp_en = 1'b0;
   bit          gaps = 1'b0;

   logic        sva, svb, rdy_a, rdy_b, drop_a, drop_b;
   logic [63:0] ma_tdata, mb_tdata;
   logic [7:0]  ma_tkeep, mb_tkeep, ma_tid, mb_tid;
   logic        ma_tvalid, mb_tvalid, ma_tlast, mb_tlast, ma_tuser, mb_tuser;
   logic [2:0]  ma_tdest, mb_tdest;
   beat_t       pa, pb;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int drops_a = 0;
   int drops_b = 0;
   int exp_drops = 0;
   exp_t exp_q[$];
   bit    stall [2];
   beat_t held  [2];

   assign sva = s_tvalid && (sel == 0);
   assign svb = s_tvalid && (sel == 1);
   assign pa  = {ma_tdata, ma_tkeep, ma_tlast, ma_tid, ma_tdest, ma_tuser};
   assign pb  = {mb_tdata, mb_tkeep, mb_tlast, mb_tid, mb_tdest, mb_tuser};

   axis_dest_classifier dut_a (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(sva),
      .s_axis_tready(rdy_a), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(ma_tdata), .m_axis_tkeep(ma_tkeep), .m_axis_tvalid(ma_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(ma_tlast), .m_axis_tid(ma_tid),
      .m_axis_tdest(ma_tdest), .m_axis_tuser(ma_tuser),
      .drop_frame(drop_a)
   );

   axis_dest_classifier #(.DEST_MAP({3'd5, 3'd2, 3'd1, 3'd0})) dut_b (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(svb),
      .s_axis_tready(rdy_b), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(mb_tdata), .m_axis_tkeep(mb_tkeep), .m_axis_tvalid(mb_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(mb_tlast), .m_axis_tid(mb_tid),
      .m_axis_tdest(mb_tdest), .m_axis_tuser(mb_tuser),
      .drop_frame(drop_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input string msg);
      n_checks++;
      n_errors++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   function automatic int model_dest(input int which, input int key);
      return (which == 0) ? map_a[key] : map_b[key];
   endfunction

   // ---------------------------------------------------------------- monitor
   task automatic mon_port(input int idx, input logic v, input beat_t b);
      exp_t e;
      if (stall[idx]) check($sformatf("hold_stable_%0d", idx), 128'({v, b}), 128'({1'b1, held[idx]}));
      stall[idx] = v && !m_tready;
      held[idx]  = b;
      if (v && m_tready) begin
         if (exp_q.size() == 0) begin
            fail_now($sformatf("unexpected_beat_%0d", idx), $sformatf("got %0h, queue empty", b));
         end else begin
            e = exp_q.pop_front();
            check("beat_dut", 128'(idx), 128'(e.dut));
            check("beat", 128'(b), 128'(e.b));
            if (e.lat) check("latency", 128'(cyc), 128'(e.cyc + 1));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall[0] = 1'b0;
         stall[1] = 1'b0;
      end else begin
         mon_port(0, ma_tvalid, pa);
         mon_port(1, mb_tvalid, pb);
         if (drop_a) drops_a++;
         if (drop_b) drops_b++;
      end
   end

   // ----------------------------------------------------------------- driver
   task automatic wait_accept(output int acc_cyc, output bit ok);
      ok = 1'b0;
      acc_cyc = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if ((sel == 0) ? rdy_a : rdy_b) begin
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            ok = 1'b1;
            return;
         end
      end
      fail_now("accept_timeout", "s_axis_tready never asserted within 200 cycles");
   endtask

   // later_key / in_dest < 0 means random; abort_after > 0 resets after that beat.
   task automatic send_frame(input int n, input int key, input int later_key,
                             input int in_dest, input bit lat, input int abort_after);
      int   d, acc;
      bit   ok, dropped;
      exp_t e;
      d       = model_dest(sel, key);
      dropped = DROP_EN && (sel == 1) && (d >= M_COUNT);
      if (dropped) exp_drops++;
      for (int i = 0; i < n; i++) begin
         s_tdata = {$urandom, $urandom};
         if (i == 0) s_tdata[1:0] = 2'(key);
         else if (later_key >= 0) s_tdata[1:0] = 2'(later_key);
         s_tkeep  = 8'($urandom);
         s_tid    = 8'($urandom);
         s_tuser  = 1'($urandom);
         s_tdest  = (in_dest >= 0) ? 3'(in_dest) : 3'($urandom);
         s_tlast  = (i == n - 1);
         s_tvalid = 1'b1;
         wait_accept(acc, ok);
         if (!ok) begin
            s_tvalid = 1'b0;
            return;
         end
         if (!dropped) begin
            e.b   = '{data: s_tdata, keep: s_tkeep, last: s_tlast, id: s_tid,
                      dest: 3'(d), user: s_tuser};
            e.dut = sel;
            e.cyc = acc;
            e.lat = lat;
            exp_q.push_back(e);
         end
         if (abort_after == i + 1) begin
            s_tvalid = 1'b0;
            rst = 1'b1;
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         fail_now("drain_timeout", $sformatf("%0d beats never emitted", exp_q.size()));
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // --------------------------------------------------------------- sequence
   initial begin
      // Reset held for 3 cycles with valid asserted.
      s_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_ready_a", 128'(rdy_a), 128'(0));
         check("rst_valid_a", 128'(ma_tvalid), 128'(0));
         check("rst_ready_b", 128'(rdy_b), 128'(0));
         check("rst_valid_b", 128'(mb_tvalid), 128'(0));
      end
      rst      = 1'b0;
      s_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready_a", 128'(rdy_a), 128'(1));
      check("post_rst_ready_b", 128'(rdy_b), 128'(1));
      check("post_rst_drop", 128'({drop_a, drop_b}), 128'(0));

      // Mapping: one single-beat frame per key, full throughput.
      for (int k = 0; k < 4; k++) send_frame(1, k, -1, -1, 1'b1, 0);
      drain();

      // Hold: later beats carry key 1 and tdest 7, which must be ignored.
      send_frame(5, 2, 1, 7, 1'b1, 0);
      drain();

      // Backpressure with random frame lengths, keys and input gaps.
      bp_en = 1'b1;
      gaps  = 1'b1;
      for (int f = 0; f < 100; f++) send_frame($urandom_range(1, 8), $urandom_range(0, 3), -1, -1, 1'b0, 0);
      drain();
      bp_en = 1'b0;
      gaps  = 1'b0;
      drain();

      // Unroutable frame on dut_b, followed by a routable one.
      sel = 1;
      send_frame(3, 3, -1, -1, 1'b1, 0);
      send_frame(2, 1, -1, -1, 1'b1, 0);
      drain();
      sel = 0;

      // Reset in the middle of a 4-beat frame, then a fresh key-1 frame.
      send_frame(4, 3, -1, -1, 1'b0, 2);
      check("midrst_valid_a", 128'(ma_tvalid), 128'(0));
      check("midrst_queue", 128'(exp_q.size()), 128'(0));
      send_frame(3, 1, 2, -1, 1'b1, 0);
      drain();

      check("drop_pulses_b", 128'(drops_b), 128'(exp_drops));
      check("drop_pulses_a", 128'(drops_a), 128'(0));
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
